// File: rtl/nv_nvdla_csb_pkg.sv
// Shared types and constants for the CSB two-master arbiter.
// The FSM encoding, CSB channel widths and the default timeout read data live here.
package nv_nvdla_csb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] ERR_DATA_DFLT = 32'hDEAD_DEAD;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } csb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc8(input logic [CNT_W-1:0] val);
    if (val == 8'hFF) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_rr2.sv
// Two-input round-robin picker: a lone valid wins, and on a tie rr_ptr names the winner.
// Produces a one-hot grant, or all zeros when nothing is valid.
module nv_nvdla_csb_rr2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  // Grant decode from the request vector and tie-break pointer
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (rr_ptr) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/nv_nvdla_csb_arb.sv
// Round-robin arbiter sharing the NVDLA CSB port between two requesters, with one
// outstanding read, read-data routing back to the issuer and a hung-read timeout.
module nv_nvdla_csb_arb
  import nv_nvdla_csb_pkg::*;
#(
  parameter int                 TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0]  ERR_DATA    = ERR_DATA_DFLT
) (
  input  logic              pclk,
  input  logic              prst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdat,
  input  logic              req0_write,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rerr,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdat,
  input  logic              req1_write,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rerr,

  output logic              csb2nvdla_valid,
  input  logic              csb2nvdla_ready,
  output logic [ADDR_W-1:0] csb2nvdla_addr,
  output logic [DATA_W-1:0] csb2nvdla_wdat,
  output logic              csb2nvdla_write,
  output logic              csb2nvdla_nposted,

  input  logic              nvdla2csb_valid,
  input  logic [DATA_W-1:0] nvdla2csb_data,

  output logic              timeout_sticky,
  output logic [CNT_W-1:0]  late_drop_cnt
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  csb_state_e        state_r;
  csb_state_e        state_nxt_s;
  logic              rr_ptr_r;
  logic              owner_r;
  logic [15:0]       timer_r;
  logic              sticky_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [DATA_W-1:0] hold_wdat_r;
  logic              hold_write_r;

  logic [1:0]        grant_s;
  logic              sel_s;
  logic              sel_valid_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdat_s;
  logic              sel_write_s;
  logic              idle_s;
  logic              accept_s;
  logic              rd_accept_s;
  logic              tmo_hit_s;
  logic              resp_s;
  logic              tmo_err_s;

  nv_nvdla_csb_rr2 u_rr2 (
    .valid  ({req1_valid, req0_valid}),
    .rr_ptr (rr_ptr_r),
    .grant  (grant_s)
  );

  // With no request pending, the rr_ptr side still drives the CSB address/data lines
  always_comb begin
    if (grant_s[1]) begin
      sel_s = 1'b1;
    end else if (grant_s[0]) begin
      sel_s = 1'b0;
    end else begin
      sel_s = rr_ptr_r;
    end
    if (sel_s) begin
      sel_valid_s = req1_valid;
      sel_addr_s  = req1_addr;
      sel_wdat_s  = req1_wdat;
      sel_write_s = req1_write;
    end else begin
      sel_valid_s = req0_valid;
      sel_addr_s  = req0_addr;
      sel_wdat_s  = req0_wdat;
      sel_write_s = req0_write;
    end
  end

  assign idle_s      = (state_r == IDLE);
  assign accept_s    = idle_s & ~prst & csb2nvdla_ready & (|grant_s);
  assign rd_accept_s = accept_s & ~sel_write_s;
  assign tmo_hit_s   = (timer_r == TMO_LAST);
  assign resp_s      = ~idle_s & ~prst & (nvdla2csb_valid | tmo_hit_s);
  assign tmo_err_s   = resp_s & ~nvdla2csb_valid;

  // FSM state register
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_accept_s) begin
          state_nxt_s = RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (resp_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: CSB request path, per-requester ready and read response routing
  always_comb begin
    csb2nvdla_valid   = 1'b0;
    csb2nvdla_addr    = hold_addr_r;
    csb2nvdla_wdat    = hold_wdat_r;
    csb2nvdla_write   = hold_write_r;
    csb2nvdla_nposted = 1'b0;
    req0_ready        = 1'b0;
    req1_ready        = 1'b0;
    req0_rvalid       = 1'b0;
    req0_rdata        = {DATA_W{1'b0}};
    req0_rerr         = 1'b0;
    req1_rvalid       = 1'b0;
    req1_rdata        = {DATA_W{1'b0}};
    req1_rerr         = 1'b0;
    case (state_r)
      IDLE: begin
        csb2nvdla_valid = sel_valid_s & ~prst;
        csb2nvdla_addr  = sel_addr_s;
        csb2nvdla_wdat  = sel_wdat_s;
        csb2nvdla_write = sel_write_s;
        req0_ready      = accept_s & grant_s[0];
        req1_ready      = accept_s & grant_s[1];
      end
      RD_WAIT: begin
        if (resp_s && owner_r) begin
          req1_rvalid = 1'b1;
          req1_rerr   = tmo_err_s;
          req1_rdata  = nvdla2csb_valid ? nvdla2csb_data : ERR_DATA;
        end else if (resp_s) begin
          req0_rvalid = 1'b1;
          req0_rerr   = tmo_err_s;
          req0_rdata  = nvdla2csb_valid ? nvdla2csb_data : ERR_DATA;
        end else begin
          req0_rvalid = 1'b0;
          req1_rvalid = 1'b0;
        end
      end
      default: begin
        csb2nvdla_valid = 1'b0;
      end
    endcase
  end

  // Arbitration pointer, read owner and the outstanding read's request copy
  always_ff @(posedge pclk) begin
    if (prst) begin
      rr_ptr_r     <= 1'b0;
      owner_r      <= 1'b0;
      hold_addr_r  <= {ADDR_W{1'b0}};
      hold_wdat_r  <= {DATA_W{1'b0}};
      hold_write_r <= 1'b0;
    end else if (accept_s) begin
      rr_ptr_r <= ~grant_s[1];
      if (rd_accept_s) begin
        owner_r      <= grant_s[1];
        hold_addr_r  <= sel_addr_s;
        hold_wdat_r  <= sel_wdat_s;
        hold_write_r <= sel_write_s;
      end
    end
  end

  // Read timer restarts on acceptance and runs for the whole wait
  always_ff @(posedge pclk) begin
    if (prst) begin
      timer_r <= 16'd0;
    end else if (rd_accept_s) begin
      timer_r <= 16'd0;
    end else if (!idle_s) begin
      timer_r <= timer_r + 16'd1;
    end
  end

  // Status: sticky timeout flag and saturating count of stray returns seen in IDLE
  always_ff @(posedge pclk) begin
    if (prst) begin
      sticky_r   <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (tmo_err_s) begin
        sticky_r <= 1'b1;
      end
      if (idle_s && nvdla2csb_valid) begin
        drop_cnt_r <= sat_inc8(drop_cnt_r);
      end
    end
  end

  assign timeout_sticky = sticky_r;
  assign late_drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_nv_nvdla_csb_arb.sv
// Directed self-checking bench for nv_nvdla_csb_arb with an 8-cycle read timeout.
module tb_nv_nvdla_csb_arb;

  logic        pclk = 1'b0;
  logic        prst;
  logic        req0_valid, req0_ready, req0_write, req0_rvalid, req0_rerr;
  logic [15:0] req0_addr;
  logic [31:0] req0_wdat, req0_rdata;
  logic        req1_valid, req1_ready, req1_write, req1_rvalid, req1_rerr;
  logic [15:0] req1_addr;
  logic [31:0] req1_wdat, req1_rdata;
  logic        csb2nvdla_valid, csb2nvdla_ready, csb2nvdla_write, csb2nvdla_nposted;
  logic [15:0] csb2nvdla_addr;
  logic [31:0] csb2nvdla_wdat;
  logic        nvdla2csb_valid;
  logic [31:0] nvdla2csb_data;
  logic        timeout_sticky;
  logic [7:0]  late_drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  nv_nvdla_csb_arb #(.TIMEOUT_CYC(8)) dut (
    .pclk              (pclk),
    .prst              (prst),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_addr         (req0_addr),
    .req0_wdat         (req0_wdat),
    .req0_write        (req0_write),
    .req0_rvalid       (req0_rvalid),
    .req0_rdata        (req0_rdata),
    .req0_rerr         (req0_rerr),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_addr         (req1_addr),
    .req1_wdat         (req1_wdat),
    .req1_write        (req1_write),
    .req1_rvalid       (req1_rvalid),
    .req1_rdata        (req1_rdata),
    .req1_rerr         (req1_rerr),
    .csb2nvdla_valid   (csb2nvdla_valid),
    .csb2nvdla_ready   (csb2nvdla_ready),
    .csb2nvdla_addr    (csb2nvdla_addr),
    .csb2nvdla_wdat    (csb2nvdla_wdat),
    .csb2nvdla_write   (csb2nvdla_write),
    .csb2nvdla_nposted (csb2nvdla_nposted),
    .nvdla2csb_valid   (nvdla2csb_valid),
    .nvdla2csb_data    (nvdla2csb_data),
    .timeout_sticky    (timeout_sticky),
    .late_drop_cnt     (late_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    prst = 1'b1;
    req0_valid = 1'b1; req0_addr = 16'h0000; req0_wdat = 32'h0; req0_write = 1'b0;
    req1_valid = 1'b0; req1_addr = 16'h0000; req1_wdat = 32'h0; req1_write = 1'b0;
    csb2nvdla_ready = 1'b1; nvdla2csb_valid = 1'b0; nvdla2csb_data = 32'h0;
    tick(); tick();
    #1;
    chk("rst_csb_valid", {31'd0, csb2nvdla_valid}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_rvalid0", {31'd0, req0_rvalid}, 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_sticky", {31'd0, timeout_sticky}, 32'd0);
    chk("rst_drop", {24'd0, late_drop_cnt}, 32'd0);

    // Back-to-back writes from both: grants alternate 0,1,0,1
    tick();
    prst = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h0100; req0_wdat = 32'hA0A0_0000;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h0200; req1_wdat = 32'hB1B1_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("wr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("wr_addr", {16'd0, csb2nvdla_addr}, (i % 2 == 0) ? 32'h0100 : 32'h0200);
      chk("wr_valid", {31'd0, csb2nvdla_valid}, 32'd1);
      chk("wr_nposted", {31'd0, csb2nvdla_nposted}, 32'd0);
      tick();
    end

    // Return arrives on the exact timeout cycle: real data wins
    req1_valid = 1'b0;
    req0_write = 1'b0; req0_addr = 16'h0030;
    #1;
    chk("co_accept", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk("co_wait_rvalid", {31'd0, req0_rvalid}, 32'd0);
      chk("co_wait_csbv", {31'd0, csb2nvdla_valid}, 32'd0);
      tick();
    end
    nvdla2csb_valid = 1'b1; nvdla2csb_data = 32'hCAFE_F00D;
    #1;
    chk("co_rvalid", {31'd0, req0_rvalid}, 32'd1);
    chk("co_rerr", {31'd0, req0_rerr}, 32'd0);
    chk("co_rdata", req0_rdata, 32'hCAFE_F00D);
    chk("co_rvalid1", {31'd0, req1_rvalid}, 32'd0);
    tick();
    nvdla2csb_valid = 1'b0;
    #1;
    chk("co_sticky", {31'd0, timeout_sticky}, 32'd0);
    chk("co_drop", {24'd0, late_drop_cnt}, 32'd0);

    // req0 read returning after 5 cycles while req1 waits
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 16'h0010;
    #1;
    chk("rd_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rd_addr", {16'd0, csb2nvdla_addr}, 32'h0010);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h0200;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk("rd_hold_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rd_wait_rvalid0", {31'd0, req0_rvalid}, 32'd0);
      chk("rd_hold_addr", {16'd0, csb2nvdla_addr}, 32'h0010);
      tick();
    end
    nvdla2csb_valid = 1'b1; nvdla2csb_data = 32'h1234_5678;
    #1;
    chk("rd_rvalid0", {31'd0, req0_rvalid}, 32'd1);
    chk("rd_rdata0", req0_rdata, 32'h1234_5678);
    chk("rd_rerr0", {31'd0, req0_rerr}, 32'd0);
    chk("rd_rvalid1", {31'd0, req1_rvalid}, 32'd0);
    chk("rd_rdata1", req1_rdata, 32'd0);
    chk("rd_ready1_ret", {31'd0, req1_ready}, 32'd0);
    tick();
    nvdla2csb_valid = 1'b0;
    #1;
    chk("rd_next_grant1", {31'd0, req1_ready}, 32'd1);
    chk("rd_next_addr", {16'd0, csb2nvdla_addr}, 32'h0200);
    chk("rd_no_repeat", {31'd0, req0_rvalid}, 32'd0);
    tick();
    req1_valid = 1'b0;

    // req1 read with no return times out after 8 cycles
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0020;
    #1;
    chk("to_accept", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk("to_wait_rvalid1", {31'd0, req1_rvalid}, 32'd0);
      tick();
    end
    #1;
    chk("to_rvalid1", {31'd0, req1_rvalid}, 32'd1);
    chk("to_rerr1", {31'd0, req1_rerr}, 32'd1);
    chk("to_rdata1", req1_rdata, 32'hDEAD_DEAD);
    chk("to_rvalid0", {31'd0, req0_rvalid}, 32'd0);
    tick();
    #1;
    chk("to_sticky", {31'd0, timeout_sticky}, 32'd1);
    chk("to_no_repeat", {31'd0, req1_rvalid}, 32'd0);
    tick();
    tick();
    nvdla2csb_valid = 1'b1; nvdla2csb_data = 32'h0000_0055;
    #1;
    chk("late_rvalid1", {31'd0, req1_rvalid}, 32'd0);
    chk("late_rvalid0", {31'd0, req0_rvalid}, 32'd0);
    tick();
    nvdla2csb_valid = 1'b0;
    #1;
    chk("late_drop", {24'd0, late_drop_cnt}, 32'd1);

    // CSB backpressure with both valid; rr_ptr winner (req0) goes first
    csb2nvdla_ready = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h0100;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_addr", {16'd0, csb2nvdla_addr}, 32'h0100);
      tick();
    end
    csb2nvdla_ready = 1'b1;
    #1;
    chk("bp_rel_ready0", {31'd0, req0_ready}, 32'd1);
    chk("bp_rel_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    #1;
    chk("bp_next_ready1", {31'd0, req1_ready}, 32'd1);
    chk("bp_next_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset in the middle of a read wait
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 16'h0040;
    #1;
    chk("pr_accept", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("pr_wait_csbv", {31'd0, csb2nvdla_valid}, 32'd0);
    tick();
    prst = 1'b1;
    #1;
    chk("pr_in_rst_rvalid1", {31'd0, req1_rvalid}, 32'd0);
    tick();
    prst = 1'b0;
    nvdla2csb_valid = 1'b1; nvdla2csb_data = 32'h0000_0077;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 16'h0050;
    #1;
    chk("pr_sticky_clr", {31'd0, timeout_sticky}, 32'd0);
    chk("pr_drop_clr", {24'd0, late_drop_cnt}, 32'd0);
    chk("pr_rvalid1", {31'd0, req1_rvalid}, 32'd0);
    chk("pr_rvalid0", {31'd0, req0_rvalid}, 32'd0);
    chk("pr_new_grant", {31'd0, req0_ready}, 32'd1);
    tick();
    nvdla2csb_valid = 1'b0;
    req0_valid = 1'b0;
    #1;
    chk("pr_late_drop", {24'd0, late_drop_cnt}, 32'd1);
    chk("pr_rdwait_csbv", {31'd0, csb2nvdla_valid}, 32'd0);
    chk("pr_hold_addr", {16'd0, csb2nvdla_addr}, 32'h0050);
    tick();
    nvdla2csb_valid = 1'b1; nvdla2csb_data = 32'h0BAD_F00D;
    #1;
    chk("pr_ret_rvalid0", {31'd0, req0_rvalid}, 32'd1);
    chk("pr_ret_rdata0", req0_rdata, 32'h0BAD_F00D);
    tick();
    nvdla2csb_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_csb_arb.md
# nv_nvdla_csb_arb

Two-master arbiter in front of the NVDLA CSB target port. It shares the single csb2nvdla/nvdla2csb channel between requester 0 (the APB-to-CSB bridge) and requester 1 (the firmware/sequencer master), using round-robin grant. It allows one outstanding non-posted read, routes read data back to the issuing requester, and converts a hung read into an error response after a programmable timeout.

## Interface
- TIMEOUT_CYC, default 1024: cycles in RD_WAIT before a read is force-completed with error; legal range 2..65535.
- ERR_DATA, default 32'hDEAD_DEAD: rdata returned on timeout.
- pclk  in  1  clock; all logic on the rising edge.
- prst  in  1  reset, synchronous, active-high.
- reqN_valid  in  1  request N (N = 0, 1) presents a transaction.
- reqN_ready  out  1  request N accepted this cycle.
- reqN_addr  in  16  word address.
- reqN_wdat  in  32  write data.
- reqN_write  in  1  1 = write, 0 = read.
- reqN_rvalid  out  1  one-cycle read-response pulse to N.
- reqN_rdata  out  32  read data; valid only with reqN_rvalid.
- reqN_rerr  out  1  response is a timeout error; qualified by reqN_rvalid.
- csb2nvdla_valid  out  1  CSB request valid.
- csb2nvdla_ready  in  1  CSB request accepted.
- csb2nvdla_addr  out  16  forwarded address.
- csb2nvdla_wdat  out  32  forwarded write data.
- csb2nvdla_write  out  1  forwarded write flag.
- csb2nvdla_nposted  out  1  tied 0; writes are posted.
- nvdla2csb_valid  in  1  read data return.
- nvdla2csb_data  in  32  read data.
- timeout_sticky  out  1  set on any timeout; cleared only by prst.
- late_drop_cnt  out  8  count of nvdla2csb_valid pulses received in IDLE, saturating at 255.

## Operation
- States: IDLE and RD_WAIT. Registers: state, rr_ptr (which requester wins a tie), owner, 16-bit timer, timeout_sticky, late_drop_cnt.
- Arbitration in IDLE is combinational. If exactly one request is valid, it wins. If both are valid, rr_ptr wins. The selected request's addr, wdat, and write drive the CSB outputs, and csb2nvdla_valid equals its valid.
- reqN_ready = (state == IDLE) & granted-N & csb2nvdla_ready. The loser sees ready = 0.
- Accepted write: stay in IDLE. rr_ptr becomes the other requester.
- Accepted read: go to RD_WAIT. Set owner to the granted requester, timer to 0, and rr_ptr to the other requester.
- RD_WAIT:
  - csb2nvdla_valid = 0 and both reqN_ready = 0.
  - The timer increments every cycle.
  - On nvdla2csb_valid: assert reqN_rvalid for owner with rdata = nvdla2csb_data and rerr = 0, in the same cycle (combinational pass-through). Go to IDLE next cycle.
  - Otherwise, when timer == TIMEOUT_CYC-1: pulse owner rvalid with rdata = ERR_DATA and rerr = 1, set timeout_sticky, go to IDLE.
  - If nvdla2csb_valid arrives in the same cycle as the timeout, real data wins: rerr = 0 and the sticky bit is not set.
- In IDLE, nvdla2csb_valid is a late or stray response. It is dropped and late_drop_cnt increments, saturating at 255. Dropping it does not block a new grant in the same cycle.
- The non-owner's rvalid is always 0. rdata outputs are 0 when rvalid is 0.
- The CSB outputs (addr, wdat, write) hold the selected request even when csb2nvdla_valid = 0. In RD_WAIT they hold the accepted read's request.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, timer = 0, timeout_sticky = 0, late_drop_cnt = 0.
  - All rvalid, rerr, rdata, and ready outputs = 0.
  - csb2nvdla_valid = 0 unless a request is asserted during reset; reset gates it to 0.
- Request path: zero-cycle latency, combinational from reqN to csb2nvdla.
- Back-to-back writes: one per cycle, alternating when both requesters are valid.
- Read return: rvalid in the same cycle as nvdla2csb_valid. The earliest next grant is the following cycle.
- Read acceptance through the timeout response takes exactly TIMEOUT_CYC cycles.
- prst asserted mid-RD_WAIT: the next cycle is IDLE with no response to owner. A subsequent nvdla2csb_valid counts as a late drop.

## Structure
- Shared package nv_nvdla_csb_pkg holds:
  - the state enum (IDLE, RD_WAIT);
  - CSB width constants: ADDR_W = 16, DATA_W = 32;
  - the default ERR_DATA.
- One sub-module, nv_nvdla_csb_rr2: two-input round-robin picker (valids and rr_ptr in, grant one-hot out). Everything else lives in the top level.

## Test plan
- Both requesters write every cycle with csb2nvdla_ready = 1 -> grants alternate 0,1,0,1; addresses appear in that order; nposted stays 0.
- req0 reads 16'h0010; CSB returns 32'h1234_5678 after 5 cycles -> req0_rvalid pulses once with that data and rerr = 0; req1 is held off (ready = 0) for exactly those cycles.
- TIMEOUT_CYC = 8; req1 reads with no return -> req1_rvalid, rerr = 1, rdata = 32'hDEAD_DEAD exactly 8 cycles after acceptance; timeout_sticky = 1; a late nvdla2csb_valid 3 cycles later -> late_drop_cnt = 1 and no rvalid.
- nvdla2csb_valid on the exact timeout cycle -> real data delivered, rerr = 0, timeout_sticky stays 0.
- csb2nvdla_ready = 0 for 4 cycles with both valid -> no ready to either requester; on release the rr_ptr winner is accepted first.
- prst pulsed in RD_WAIT -> all outputs return to reset values next cycle; a new read is granted immediately afterwards.
